// File: rtl/io_debounce.sv
// Three-channel input debouncer (SW0, SW1, PB0) with two-flop synchronizers,
// per-channel saturating stability counters, a PB0 rise pulse and a sticky press flag.
module io_debounce #(
  parameter int unsigned DB_LIMIT  = 50000,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_sw0,
  input  logic raw_sw1,
  input  logic raw_pb0,
  input  logic rd_ack,
  output logic io_sw0,
  output logic io_sw1,
  output logic io_pb0,
  output logic pb0_pulse,
  output logic pb0_press
);

  localparam int unsigned NCH = 3;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DB_LIMIT - 1);

  // Channel index: 0 = SW0, 1 = SW1, 2 = PB0
  logic [NCH-1:0]       raw_s;
  logic [NCH-1:0]       s1_q;
  logic [NCH-1:0]       s2_q;
  logic [NCH-1:0]       stable_q;
  logic [NCH-1:0]       stable_d;
  logic [CNT_WIDTH-1:0] cnt_q [NCH];
  logic [CNT_WIDTH-1:0] cnt_d [NCH];
  logic                 pulse_q;
  logic                 pulse_d;
  logic                 press_q;
  logic                 press_d;
  logic                 pb_rise_s;

  assign raw_s = {raw_pb0, raw_sw1, raw_sw0};

  // Counter only advances while the synchronized input disagrees with the debounced level
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(NCH); i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end
    end
  end

  // A press being set wins over an acknowledge on the same edge
  always_comb begin
    pb_rise_s = ~stable_q[2] & stable_d[2];
    pulse_d   = pb_rise_s;
    if (pb_rise_s) begin
      press_d = 1'b1;
    end else if (rd_ack) begin
      press_d = 1'b0;
    end else begin
      press_d = press_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        cnt_q[i] <= '0;
      end
      pulse_q  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      s1_q     <= raw_s;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      for (int i = 0; i < int'(NCH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pulse_q  <= pulse_d;
      press_q  <= press_d;
    end
  end

  assign io_sw0    = stable_q[0];
  assign io_sw1    = stable_q[1];
  assign io_pb0    = stable_q[2];
  assign pb0_pulse = pulse_q;
  assign pb0_press = press_q;

endmodule

// File: tb/tb_io_debounce.sv
// Self-checking bench for io_debounce (DB_LIMIT=4): directed scenarios followed by
// random stimulus, all compared against a sliding-window reference model.
module tb_io_debounce;

  localparam int DBL = 4;
  localparam int HL  = DBL + 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic raw_sw0 = 1'b0;
  logic raw_sw1 = 1'b0;
  logic raw_pb0 = 1'b0;
  logic rd_ack = 1'b0;
  logic io_sw0, io_sw1, io_pb0, pb0_pulse, pb0_press;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Model: raw samples per channel, oldest first; the newest is the current edge's sample.
  // The level flips when the samples from 2..DBL+1 edges ago all disagree with it.
  bit hist [3][HL];
  bit m_stable [3];
  bit m_pulse;
  bit m_press;

  io_debounce #(.DB_LIMIT(DBL), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .raw_sw0(raw_sw0), .raw_sw1(raw_sw1), .raw_pb0(raw_pb0), .rd_ack(rd_ack),
    .io_sw0(io_sw0), .io_sw1(io_sw1), .io_pb0(io_pb0),
    .pb0_pulse(pb0_pulse), .pb0_press(pb0_press)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < HL; k++) hist[c][k] = 1'b0;
      m_stable[c] = 1'b0;
    end
    m_pulse = 1'b0;
    m_press = 1'b0;
  endfunction

  function automatic void model_edge(bit r0, bit r1, bit r2, bit ack, bit rn);
    bit raw [3];
    bit rise;
    bit all_diff;
    raw[0] = r0; raw[1] = r1; raw[2] = r2;
    if (!rn) begin
      model_reset();
    end else begin
      rise = 1'b0;
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < HL - 1; k++) hist[c][k] = hist[c][k+1];
        hist[c][HL-1] = raw[c];
        all_diff = 1'b1;
        for (int k = 0; k < DBL; k++) if (hist[c][k] == m_stable[c]) all_diff = 1'b0;
        if (all_diff) begin
          if (c == 2 && !m_stable[2]) rise = 1'b1;
          m_stable[c] = ~m_stable[c];
        end
      end
      m_pulse = rise;
      if (rise) m_press = 1'b1;
      else if (ack) m_press = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then compare all outputs.
  task automatic step(input string tag, input bit s0, input bit s1, input bit p0,
                      input bit ack, input bit rn);
    raw_sw0 = s0; raw_sw1 = s1; raw_pb0 = p0; rd_ack = ack; reset_n = rn;
    @(posedge clock);
    model_edge(s0, s1, p0, ack, rn);
    #1;
    chk({tag, ".io_sw0"},    io_sw0,    m_stable[0]);
    chk({tag, ".io_sw1"},    io_sw1,    m_stable[1]);
    chk({tag, ".io_pb0"},    io_pb0,    m_stable[2]);
    chk({tag, ".pb0_pulse"}, pb0_pulse, m_pulse);
    chk({tag, ".pb0_press"}, pb0_press, m_press);
  endtask

  initial begin
    bit r0, r1, r2, ak, rn;
    model_reset();
    #1;
    step("init_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("init_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with all raw inputs high
    step("rst_all_hi", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_all_hi.const_sw0", io_sw0, 1'b0);
    chk("rst_all_hi.const_press", pb0_press, 1'b0);
    repeat (8) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // SW0 rises and is held: output changes at edge DB_LIMIT+1
    for (int e = 0; e <= 7; e++) begin
      step("sw0_latency", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("sw0_latency.e%0d", e), io_sw0, (e >= DBL + 1) ? 1'b1 : 1'b0);
      chk($sformatf("sw0_latency.sw1_e%0d", e), io_sw1, 1'b0);
    end

    // SW1 glitch of DB_LIMIT-1 samples is rejected
    for (int e = 0; e < 12; e++) begin
      step("sw1_glitch", 1'b1, (e < DBL - 1) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("sw1_glitch.e%0d", e), io_sw1, 1'b0);
    end

    // PB0 press: single pulse, sticky flag, cleared by acknowledge
    for (int e = 0; e < 10; e++) begin
      step("pb0_press", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk($sformatf("pb0_press.pulse_e%0d", e), pb0_pulse, (e == DBL + 1) ? 1'b1 : 1'b0);
      chk($sformatf("pb0_press.flag_e%0d", e), pb0_press, (e >= DBL + 1) ? 1'b1 : 1'b0);
    end
    step("pb0_ack", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("pb0_ack.const", pb0_press, 1'b0);
    repeat (8) step("pb0_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pb0_release.level", io_pb0, 1'b0);

    // Acknowledge coincident with the rising update keeps the flag set
    for (int e = 0; e <= DBL + 2; e++) begin
      step("ack_collide", 1'b1, 1'b0, 1'b1, (e == DBL + 1) ? 1'b1 : 1'b0, 1'b1);
    end
    chk("ack_collide.flag", pb0_press, 1'b1);
    step("ack_clear", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (8) step("settle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-count on SW0; rise comes DB_LIMIT+1 edges after the first post-reset sample
    for (int e = 0; e <= 11; e++) begin
      step("sw0_midrst", 1'b1, 1'b0, 1'b0, (e == 3) ? 1'b1 : 1'b0, (e == 3) ? 1'b0 : 1'b1);
      chk($sformatf("sw0_midrst.e%0d", e), io_sw0, (e >= 4 + DBL + 1) ? 1'b1 : 1'b0);
    end

    // Random traffic including short glitches, acknowledges and occasional resets
    r0 = 1'b1; r1 = 1'b0; r2 = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) r0 = ~r0;
      if ($urandom_range(0, 5) == 0) r1 = ~r1;
      if ($urandom_range(0, 4) == 0) r2 = ~r2;
      ak = ($urandom_range(0, 6) == 0);
      rn = ($urandom_range(0, 99) != 0);
      step("rand", r0, r1, r2, ak, rn);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/io_debounce.md
IO_DEBOUNCE -- requirements
Module: io_debounce

Interface
REQ-001: Parameter DB_LIMIT, default 50000, is the number of consecutive clock cycles a synchronized input must differ from its debounced level before that level changes; legal range is 2 to 65535.
REQ-002: Parameter CNT_WIDTH, default 16, is the width of each per-channel debounce counter and SHALL hold DB_LIMIT-1.
REQ-003: One clock; reset is synchronous and active-low.
REQ-004: clock  input  1  system clock; all state updates on its rising edge.
REQ-005: reset_n  input  1  synchronous active-low reset.
REQ-006: raw_sw0  input  1  asynchronous sliding switch SW0.
REQ-007: raw_sw1  input  1  asynchronous sliding switch SW1.
REQ-008: raw_pb0  input  1  asynchronous pushbutton PB0, 1 = pressed.
REQ-009: rd_ack  input  1  one-cycle strobe, high when the CPU reads input port 0xfff0; clears pb0_press.
REQ-010: io_sw0  output  1  debounced SW0 level, feeds the data memory/IO block switch input 0.
REQ-011: io_sw1  output  1  debounced SW1 level, feeds the data memory/IO block switch input 1.
REQ-012: io_pb0  output  1  debounced PB0 level.
REQ-013: pb0_pulse  output  1  one-cycle pulse on each debounced PB0 rising edge.
REQ-014: pb0_press  output  1  sticky PB0-pressed flag, held until acknowledged.

Function
REQ-015: Each raw input SHALL pass through its own two-flop synchronizer (s1, s2) before any other logic sees it.
REQ-016: Each channel SHALL have a registered debounced level (stable) and a CNT_WIDTH-bit counter.
REQ-017: Per edge, if s2 == stable, the counter SHALL clear to 0.
REQ-018: Per edge, if s2 != stable and counter < DB_LIMIT-1, the counter SHALL increment by 1.
REQ-019: Per edge, if s2 != stable and counter == DB_LIMIT-1, stable SHALL take s2 and the counter SHALL clear to 0.
REQ-020: Latency: a raw change first sampled at edge 0 and held SHALL change the output at edge DB_LIMIT+1 exactly.
REQ-021: Glitch rejection: a raw change lasting DB_LIMIT-1 or fewer sampled cycles SHALL never change the output.
REQ-022: The counter SHALL never wrap or exceed DB_LIMIT-1.
REQ-023: Channels are independent; simultaneous changes on several inputs SHALL be processed in parallel with identical latency.
REQ-024: io_sw0, io_sw1 and io_pb0 SHALL be the stable registers directly, with no combinational path from raw inputs.
REQ-025: pb0_pulse SHALL be registered and high exactly in the cycle in which io_pb0 first reads 1 after a 0→1 update; it SHALL be low otherwise and SHALL NOT fire on 1→0.
REQ-026: pb0_press SHALL be set on the same edge that io_pb0 updates 0→1.
REQ-027: pb0_press SHALL clear on an edge with rd_ack=1 and no simultaneous set.
REQ-028: Simultaneous set and rd_ack SHALL leave pb0_press=1 so no press is lost.
REQ-029: rd_ack while pb0_press=0 SHALL have no effect.

Reset
REQ-030: On an edge with reset_n=0, all synchronizer flops, stable registers, counters, pb0_pulse and pb0_press SHALL become 0, so all outputs are 0 in the next cycle.
REQ-031: Reset SHALL take priority over every other update, including mid-count and during rd_ack.
REQ-032: After reset release with a raw input held at 1, the output SHALL rise at edge DB_LIMIT+1 counted from the first post-reset sampling edge; for PB0 this also generates pb0_pulse and sets pb0_press.

Verification (DB_LIMIT=4)
REQ-033: Apply reset_n=0 for one edge with all raw inputs at 1 -> all five outputs are 0 after that edge.
REQ-034: Drive raw_sw0 0→1 and hold it, sampled at edge 0 -> io_sw0 is 0 through edge 4 and 1 from edge 5; io_sw1 and io_pb0 are unaffected.
REQ-035: Hold raw_sw1 high for 3 cycles, then low -> io_sw1 stays 0 throughout and its counter returns to 0.
REQ-036: Hold raw_pb0 high for 10 cycles -> io_pb0=1 from edge 5, pb0_pulse=1 for that single cycle, pb0_press=1 and held; rd_ack pulse -> pb0_press=0 after the next edge.
REQ-037: Apply rd_ack on the same edge io_pb0 rises -> pb0_press=1 afterwards.
REQ-038: Hold raw_sw0 high, assert reset_n=0 at edge 3, release at edge 4 -> io_sw0 stays 0 and rises only 5 edges after the first post-reset sampling edge.
